// File: rtl/sa_result_fifo.sv
// First-word-fall-through result FIFO that buffers systolic-array output words.
// Upstream cannot be stalled, so a word that arrives while the FIFO is full is dropped and flagged.
module sa_result_fifo #(
    parameter int OUTWIDTH = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [OUTWIDTH-1:0]        in_data,
    input  logic                       in_valid,
    output logic [OUTWIDTH-1:0]        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [OUTWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                ovf_q, ovf_d;

    logic full;
    logic push;
    logic pop;
    logic drop;

    assign full = (level_q == FULL_LEVEL);
    assign pop  = out_valid && out_ready;
    // A full FIFO can still take a word in the same cycle its head leaves.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Setting the flag takes precedence over clearing it.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Storage is read combinationally so the head word is visible without an extra stage.
    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sa_result_fifo.sv
// Self-checking bench for sa_result_fifo: a queue-based reference model is compared
// against the DUT after every clock, plus directed scenarios with literal expectations.
module tb_sa_result_fifo;

    localparam int OUTWIDTH = 8;
    localparam int DEPTH    = 4;

    logic                clk;
    logic                rst_n;
    logic [OUTWIDTH-1:0] in_data;
    logic                in_valid;
    logic [OUTWIDTH-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          level;
    logic                overflow;
    logic                clr_ovf;

    int assertCount;
    int failCount;

    // Reference model state: plain queue of stored words and a sticky flag.
    logic [OUTWIDTH-1:0] modelQ [$];
    logic                modelOvf;
    logic                mPop;
    logic                mPush;
    logic                mFull;

    logic                recordPops;
    logic [OUTWIDTH-1:0] popLog [$];

    sa_result_fifo #(
        .OUTWIDTH(OUTWIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("model.out_valid", {31'b0, out_valid}, {31'b0, (modelQ.size() != 0)});
        checkOutput("model.level", {29'b0, level}, modelQ.size());
        checkOutput("model.overflow", {31'b0, overflow}, {31'b0, modelOvf});
        checkOutput("model.level_bound", {31'b0, (level <= 3'(DEPTH))}, 32'd1);
        if (modelQ.size() != 0) begin
            checkOutput("model.out_data", {24'b0, out_data}, {24'b0, modelQ[0]});
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare at the falling edge.
    task automatic applyStimulus(input logic v, input logic [OUTWIDTH-1:0] d,
                                 input logic rdy, input logic clr, input logic rn);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        rst_n     = rn;
        if (recordPops && rn && out_valid && rdy) begin
            popLog.push_back(out_data);
        end
        @(posedge clk);
        if (!rn) begin
            modelQ.delete();
            modelOvf = 1'b0;
        end else begin
            mPop  = (modelQ.size() != 0) && rdy;
            mFull = (modelQ.size() == DEPTH);
            mPush = v && (!mFull || mPop);
            if (mPop) begin
                void'(modelQ.pop_front());
            end
            if (mPush) begin
                modelQ.push_back(d);
            end
            if (v && !mPush) begin
                modelOvf = 1'b1;
            end else if (clr) begin
                modelOvf = 1'b0;
            end
        end
        @(negedge clk);
        compareModel();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drainExpect(input logic [OUTWIDTH-1:0] e0, input logic [OUTWIDTH-1:0] e1,
                               input logic [OUTWIDTH-1:0] e2, input logic [OUTWIDTH-1:0] e3,
                               input string tag);
        logic [OUTWIDTH-1:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, ".head"}, {24'b0, out_data}, {24'b0, exp[i]});
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        checkOutput({tag, ".empty"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int pushed;
        assertCount = 0;
        failCount   = 0;
        modelOvf    = 1'b0;
        recordPops  = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        clr_ovf     = 1'b0;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.level", {29'b0, level}, 32'd0);
        checkOutput("reset.out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset.overflow", {31'b0, overflow}, 32'd0);
        checkOutput("reset.out_data", {24'b0, out_data}, 32'd0);

        // Single word, pushed on the first edge out of reset.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        checkOutput("single.out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("single.out_data", {24'b0, out_data}, 32'h5A);
        checkOutput("single.level", {29'b0, level}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("single.pop_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("single.pop_level", {29'b0, level}, 32'd0);

        // Fill and overflow.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        checkOutput("fill.no_ovf_yet", {31'b0, overflow}, 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("fill.level", {29'b0, level}, 32'd4);
        checkOutput("fill.overflow", {31'b0, overflow}, 32'd1);
        drainExpect(8'h11, 8'h22, 8'h33, 8'h44, "fill");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("fill.clr", {31'b0, overflow}, 32'd0);

        // Full with simultaneous push and pop.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        checkOutput("fullpp.level", {29'b0, level}, 32'd4);
        checkOutput("fullpp.overflow", {31'b0, overflow}, 32'd0);
        drainExpect(8'h22, 8'h33, 8'h44, 8'h55, "fullpp");

        // Overflow clear alone, then clear colliding with a drop.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        end
        checkOutput("ovfclr.set", {31'b0, overflow}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("ovfclr.alone", {31'b0, overflow}, 32'd0);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b1, 1'b1);
        checkOutput("ovfclr.set_wins", {31'b0, overflow}, 32'd1);
        checkOutput("ovfclr.head_kept", {24'b0, out_data}, 32'h60);
        drainExpect(8'h60, 8'h61, 8'h62, 8'h63, "ovfclr");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Wrap-around: ten words with random consumer readiness, never dropping one.
        recordPops = 1'b1;
        pushed = 0;
        for (int cyc = 0; cyc < 200 && (pushed < 10 || modelQ.size() != 0); cyc++) begin
            logic rdy;
            logic v;
            rdy = 1'($urandom_range(0, 1));
            v = (pushed < 10) && 1'($urandom_range(0, 1)) &&
                ((modelQ.size() < DEPTH) || (rdy && modelQ.size() != 0));
            applyStimulus(v, 8'(pushed + 1), rdy, 1'b0, 1'b1);
            if (v) pushed++;
        end
        recordPops = 1'b0;
        checkOutput("wrap.count", popLog.size(), 32'd10);
        for (int i = 0; i < popLog.size() && i < 10; i++) begin
            checkOutput("wrap.order", {24'b0, popLog[i]}, i + 1);
        end
        checkOutput("wrap.no_ovf", {31'b0, overflow}, 32'd0);

        // Reset mid-operation with overflow set and three words stored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("rstmid.level_before", {29'b0, level}, 32'd3);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        checkOutput("rstmid.level", {29'b0, level}, 32'd0);
        checkOutput("rstmid.out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstmid.overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rstmid.out_data", {24'b0, out_data}, 32'd0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        checkOutput("rstmid.push_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("rstmid.push_data", {24'b0, out_data}, 32'hA5);
        checkOutput("rstmid.push_level", {29'b0, level}, 32'd1);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 99) != 0));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sa_result_fifo.md
SA_RESULT_FIFO -- requirements
Module: sa_result_fifo

Interface
REQ-001 SHALL have parameter OUTWIDTH, default 8: width of one systolic-array result word.
REQ-002 SHALL have parameter DEPTH, default 4: number of result entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_data, input, OUTWIDTH: result word from the systolic array (its results output).
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle (the array's valid_out); no back-pressure is applied upstream.
REQ-007 SHALL have port out_data, output, OUTWIDTH: head-of-queue word.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a stored word.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts out_data this cycle.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1: number of stored words.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when a word was dropped.
REQ-012 SHALL have port clr_ovf, input, 1: clears overflow.

Function
REQ-013 SHALL store words in first-in first-out order in a DEPTH-entry register array, with read and write pointers that wrap modulo DEPTH.
REQ-014 SHALL define push = in_valid AND (not full OR pop), where full means level==DEPTH.
REQ-015 SHALL define pop = out_valid AND out_ready.
REQ-016 SHALL act first-word-fall-through: out_data SHALL equal the oldest word whenever out_valid=1, with no register stage after the storage.
REQ-017 SHALL drive out_valid = (level != 0), decoded from registered state.
REQ-018 SHALL make a word pushed at edge N visible at out_data/out_valid after edge N, giving one-cycle latency.
REQ-019 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL update level as follows:
- +1 on push only
- -1 on pop only
- unchanged on simultaneous push and pop
REQ-021 SHALL, when full, in_valid=1 and pop=1 in the same cycle, accept the new word, pop the head, and keep level at DEPTH.
REQ-022 SHALL, when full, in_valid=1 and pop=0, drop in_data, leave all contents unchanged, and set overflow=1 at the next edge.
REQ-023 SHALL, when empty, ignore out_ready; no pop occurs and the pointers do not move.
REQ-024 SHALL, when empty and in_valid=1 with out_ready=1, store the word and not bypass it; out_valid rises at the next edge.
REQ-025 SHALL clear overflow when clr_ovf=1, unless a drop occurs in the same cycle, in which case overflow SHALL be 1 (set wins).
REQ-026 SHALL have no X on out_data at any time after reset: data registers reset to 0, and out_data reads the entry at the read pointer even when empty.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set:
- both pointers = 0
- level = 0
- out_valid = 0
- overflow = 0
- all storage entries = 0
REQ-028 SHALL give rst_n priority over push, pop and clr_ovf; a reset during active traffic discards all stored words.
REQ-029 SHALL accept pushes on the first edge at which rst_n=1.

Verification
REQ-030 Single word: push 0x5A with out_ready=0 -> next cycle out_valid=1, out_data=0x5A, level=1; then out_ready=1 for one cycle -> out_valid=0, level=0.
REQ-031 Fill and overflow (DEPTH=4): push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles with out_ready=0 -> level=4, overflow=1; drained order 0x11,0x22,0x33,0x44; 0x55 never appears.
REQ-032 Full with simultaneous push and pop: with the FIFO full of 0x11..0x44, push 0x55 and out_ready=1 in the same cycle -> level=4, overflow unchanged (0), drained order 0x22,0x33,0x44,0x55.
REQ-033 Wrap-around: 10 pushes (0x01..0x0A) interleaved with random out_ready -> output sequence 0x01..0x0A with none missing or duplicated; level never exceeds 4.
REQ-034 Overflow clear: with overflow=1, assert clr_ovf alone -> overflow=0; assert clr_ovf together with a drop -> overflow stays 1.
REQ-035 Reset mid-operation: with level=3, drive rst_n=0 for one edge -> level=0, out_valid=0, overflow=0, out_data=0; a push on the next edge produces exactly that word at the output.
